// File: rtl/pipe_pkg.sv
// Shared types and standard bundle widths for pipeline boundary registers.
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } pipe_state_t;

    localparam int IFID_CTRL_W  = 1;
    localparam int IFID_DATA_W  = 64;
    localparam int IDEX_CTRL_W  = 9;
    localparam int IDEX_DATA_W  = 138;
    localparam int EXMEM_CTRL_W = 5;
    localparam int EXMEM_DATA_W = 107;
    localparam int MEMWB_CTRL_W = 2;
    localparam int MEMWB_DATA_W = 69;

endpackage

// File: rtl/pipe_slot.sv
// One stage entry (valid, ctrl, data). Clear drops valid and zeroes ctrl but keeps data;
// latency 1 cycle from load; no backpressure of its own, the parent decides when to load.
module pipe_slot
    import pipe_pkg::*;
#(
    parameter int CTRL_W = IDEX_CTRL_W,
    parameter int DATA_W = IDEX_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_load,
    input  logic              i_clear,
    input  logic [CTRL_W-1:0] i_ctrl,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_valid,
    output logic [CTRL_W-1:0] o_ctrl,
    output logic [DATA_W-1:0] o_data
);

    logic              r_valid;
    logic [CTRL_W-1:0] r_ctrl;
    logic [DATA_W-1:0] r_data;

    // ctrl is zeroed every time the slot goes invalid, so a bubble never carries live control
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_ctrl  <= '0;
            r_data  <= '0;
        end else if (i_clear) begin
            r_valid <= 1'b0;
            r_ctrl  <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_ctrl  <= i_ctrl;
            r_data  <= i_data;
        end
    end

    assign o_valid = r_valid;
    assign o_ctrl  = r_ctrl;
    assign o_data  = r_data;

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline boundary register with a two-entry skid buffer, flush and bubble masking.
// Latency 1 cycle; in_ready depends only on registered state, so the stage absorbs one extra entry after stall.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int CTRL_W = IDEX_CTRL_W,
    parameter int DATA_W = IDEX_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);

    pipe_state_t r_state;
    pipe_state_t w_state_nxt;
    logic        r_reset_q;

    logic w_accept;
    logic w_pop;
    logic w_main_load;
    logic w_main_from_skid;
    logic w_main_clr;
    logic w_skid_load;
    logic w_skid_clr;

    logic              w_main_vld;
    logic [CTRL_W-1:0] w_main_ctrl;
    logic [DATA_W-1:0] w_main_data;
    logic              w_skid_vld;
    logic [CTRL_W-1:0] w_skid_ctrl;
    logic [DATA_W-1:0] w_skid_data;
    logic [CTRL_W-1:0] w_main_ctrl_in;
    logic [DATA_W-1:0] w_main_data_in;

    assign in_ready = (r_state != FULL) && !r_reset_q;
    assign w_accept = in_valid && in_ready;
    assign w_pop    = w_main_vld && out_ready;

    always_ff @(posedge clk) begin
        r_reset_q <= reset;
        if (reset) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_main_load      = 1'b0;
        w_main_from_skid = 1'b0;
        w_main_clr       = 1'b0;
        w_skid_load      = 1'b0;
        w_skid_clr       = 1'b0;
        if (flush) begin
            w_state_nxt = EMPTY;
            w_main_clr  = 1'b1;
            w_skid_clr  = 1'b1;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (w_accept) begin
                        w_state_nxt = ONE;
                        w_main_load = 1'b1;
                    end
                end
                ONE: begin
                    if (w_accept && w_pop) begin
                        w_main_load = 1'b1;
                    end else if (w_accept) begin
                        w_state_nxt = FULL;
                        w_skid_load = 1'b1;
                    end else if (w_pop) begin
                        w_state_nxt = EMPTY;
                        w_main_clr  = 1'b1;
                    end
                end
                FULL: begin
                    if (w_pop) begin
                        w_state_nxt      = ONE;
                        w_main_load      = 1'b1;
                        w_main_from_skid = 1'b1;
                        w_skid_clr       = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = EMPTY;
                    w_main_clr  = 1'b1;
                    w_skid_clr  = 1'b1;
                end
            endcase
        end
    end

    assign w_main_ctrl_in = w_main_from_skid ? w_skid_ctrl : in_ctrl;
    assign w_main_data_in = w_main_from_skid ? w_skid_data : in_data;

    pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_main (
        .clk     (clk),
        .reset   (reset),
        .i_load  (w_main_load),
        .i_clear (w_main_clr),
        .i_ctrl  (w_main_ctrl_in),
        .i_data  (w_main_data_in),
        .o_valid (w_main_vld),
        .o_ctrl  (w_main_ctrl),
        .o_data  (w_main_data)
    );

    pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_skid (
        .clk     (clk),
        .reset   (reset),
        .i_load  (w_skid_load),
        .i_clear (w_skid_clr),
        .i_ctrl  (in_ctrl),
        .i_data  (in_data),
        .o_valid (w_skid_vld),
        .o_ctrl  (w_skid_ctrl),
        .o_data  (w_skid_data)
    );

    assign out_valid = w_main_vld;
    assign out_ctrl  = w_main_ctrl;
    assign out_data  = w_main_data;

    always_comb begin
        occupancy = 2'd0;
        case (r_state)
            ONE:     occupancy = 2'd1;
            FULL:    occupancy = w_skid_vld ? 2'd2 : 2'd1;
            default: occupancy = 2'd0;
        endcase
    end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised pipeline stage register with a valid/ready handshake, a two-entry skid buffer, flush and bubble insertion. It is the building block for every inter-stage boundary in the processor (IF/ID, ID/EX, EX/MEM, MEM/WB). It carries a control bundle and a data bundle between stages and supports stall (back-pressure) and flush (squash). Control bits are forced to zero whenever the stage holds a bubble, so a squashed instruction can never write registers or memory.

## Interface
Parameters:
- CTRL_W, default 9: control bundle width (RegDst, ALUSrc, MemRead, …, ALUOp packed).
- DATA_W, default 138: data bundle width (pcNext, operands, immediate, rt, rd packed).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  reset, synchronous, active-high.
- flush  in  1  synchronous squash of all held entries.
- in_valid  in  1  upstream offers an entry.
- in_ready  out  1  stage can accept; a pure function of registered state.
- in_ctrl  in  CTRL_W  upstream control bundle.
- in_data  in  DATA_W  upstream data bundle.
- out_valid  out  1  stage presents an entry downstream.
- out_ready  in  1  downstream consumes this cycle.
- out_ctrl  out  CTRL_W  control bundle; all-zero whenever out_valid=0.
- out_data  out  DATA_W  data bundle; holds its last loaded value when out_valid=0.
- occupancy  out  2  number of entries held (0, 1 or 2).

## Operation
- Definitions: accept = in_valid & in_ready; pop = out_valid & out_ready.
- Storage: main slot (drives the outputs) and skid slot. Each slot holds valid, ctrl and data.
- States: EMPTY, ONE (main valid), FULL (main and skid valid). in_ready = (state != FULL) & !reset_q, where reset_q is reset registered.
- EMPTY:
  - accept → ONE; main loads the input.
- ONE:
  - accept & pop → ONE; main loads the input.
  - accept & !pop → FULL; skid loads the input.
  - pop & !accept → EMPTY.
  - Otherwise hold.
- FULL:
  - pop → ONE; main loads the skid.
  - Otherwise hold. No accept is possible because in_ready=0.
- flush: → EMPTY from any state, with top priority over accept and pop.
  - An input accepted in the flush cycle is dropped.
  - out_valid=0 and out_ctrl=0 from the next cycle.
  - out_data is not cleared.
- Bubble: out_ctrl is masked to 0 whenever main is invalid. The mask is applied at the register, not combinationally on the input.
- Ordering: strict FIFO. Entries are never reordered or duplicated.
- occupancy: EMPTY=0, ONE=1, FULL=2.

## Timing
- Reset (cycle after reset high):
  - State EMPTY.
  - out_valid=0, out_ctrl=0, out_data=0, occupancy=0.
  - in_ready=0 while reset is high and for one cycle after it is released, then 1.
- Reset mid-operation: all held entries are discarded with the same result as above. It has priority over flush.
- Latency: one cycle from accept to out_valid when EMPTY.
- Throughput: one entry per cycle in steady state with out_ready=1.
- Timing paths:
  - No combinational path from out_ready to in_ready.
  - No combinational path from in_* to out_*.
- Back-pressure: after out_ready drops, the stage absorbs at most one more entry and then deasserts in_ready in the following cycle.
- Simultaneous flush and pop: the pop is counted as consumed by downstream, and the stage still ends EMPTY.
- FULL with pop: in_ready rises in the next cycle.

## Structure
- Package pipe_pkg:
  - typedef enum logic [1:0] {EMPTY, ONE, FULL} pipe_state_t.
  - Localparams for the standard stage bundle widths (IDEX_CTRL_W=9, IDEX_DATA_W=138, plus those of the other stages).
- Sub-module pipe_slot: one register entry (valid, ctrl, data) with load and clear inputs. It is instantiated twice, as main and skid.
- The top level holds the state machine, the ready logic and the ctrl mask.

## Test plan
- Reset: assert reset for 2 cycles with in_valid=1 → out_valid=0, out_ctrl=0, out_data=0, occupancy=0; in_ready=1 from the second cycle after release.
- Streaming: send 8 entries with data 1..8 back-to-back with out_ready=1 → 1..8 appear on consecutive cycles, 1 cycle after acceptance, occupancy=1 throughout.
- Stall: with entry A in main and out_ready=0, offer B and C → B accepted (occupancy=2, in_ready=0 next cycle), C held upstream; release out_ready → outputs A, B, C in order, no loss.
- Flush in FULL: hold A and B, then pulse flush together with in_valid carrying D → next cycle out_valid=0, out_ctrl=0, occupancy=0; D never appears.
- Bubble masking: in_ctrl=9'h1FF with in_valid=0 for 3 cycles → out_ctrl stays 0 and out_valid stays 0.
- Reset while FULL with out_ready=1 → nothing pops after reset; first output after release is a freshly accepted entry.
